// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game session path (session controller, BCD play
// timer, score/time display). The state encoding is the one the display and
// timer blocks decode, so values must not be reordered.
//   game_state_e  : 3-bit session state, IDLE=0 READY=1 PLAY=2 PAUSE=3
//                   WON=4 OVER=5
//   DEF_TICK_DIV  : sys_clk cycles per game second on the 50 MHz board clock
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int DEF_TICK_DIV = 50_000_000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_WON   = 3'd4,
        ST_OVER  = 3'd5
    } game_state_e;

    // The second prescaler only advances while the countdown or the game
    // itself is running.
    function automatic logic is_counting(game_state_e s);
        return (s == ST_READY) || (s == ST_PLAY);
    endfunction

endpackage

// File: rtl/game_session_if.sv
// ---------------------------------------------------------------------------
// game_session_if
// Bundle between the input decoder / game logic (master side) and the session
// controller (slave side).
//   master -> slave : start_pls, pause_pls, win_evt, lose_evt, time_max_flag
//   slave -> master : timer_clr, timer_tick, ready_cnt[2:0], state[2:0],
//                     game_won, game_over
// Handshake: there is no valid/ready back-pressure on this bundle. Every *_pls
// and *_evt input is a single-cycle pulse that the controller samples on the
// rising sys_clk edge and either acts on or drops in that same cycle;
// time_max_flag is a level. timer_clr and timer_tick are single-cycle pulses
// the timer must consume in the cycle they are high. All slave outputs are
// registered.
// ---------------------------------------------------------------------------
interface game_session_if;

    logic       start_pls;
    logic       pause_pls;
    logic       win_evt;
    logic       lose_evt;
    logic       time_max_flag;
    logic       timer_clr;
    logic       timer_tick;
    logic [2:0] ready_cnt;
    logic [2:0] state;
    logic       game_won;
    logic       game_over;

    modport master (
        output start_pls, pause_pls, win_evt, lose_evt, time_max_flag,
        input  timer_clr, timer_tick, ready_cnt, state, game_won, game_over
    );

    modport slave (
        input  start_pls, pause_pls, win_evt, lose_evt, time_max_flag,
        output timer_clr, timer_tick, ready_cnt, state, game_won, game_over
    );

endinterface

// File: rtl/sec_prescaler.sv
// ---------------------------------------------------------------------------
// sec_prescaler
// Down-counter from TICK_DIV-1 to 0 that marks one game second when it sits at
// 0 while enabled, then reloads. Holds its value while en is low, which is how
// a paused game resumes mid-second.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   en                 : advance the count this cycle
//   reload             : restart the second (takes priority over en)
//   sec_pls            : combinational, high in the cycle a second completes
// TICK_DIV must be at least 2.
// ---------------------------------------------------------------------------
module sec_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    input  logic reload,
    output logic sec_pls
);

    localparam int             CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= LOAD;
        end else if (reload) begin
            cnt_q <= LOAD;
        end else if (en) begin
            cnt_q <= (cnt_q == '0) ? LOAD : cnt_q - CW'(1);
        end
    end

    assign sec_pls = en && (cnt_q == '0);

endmodule

// File: rtl/game_session_ctrl.sv
// ---------------------------------------------------------------------------
// game_session_ctrl
// Session state machine for a cartridge: IDLE -> READY countdown -> PLAY,
// with PAUSE, WON and OVER. Drives the play timer's clear and one-second
// count tick and ends the game when the timer saturates.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : start/pause pulses, win/lose events, time_max_flag
//                        in; timer_clr, timer_tick, ready_cnt, state,
//                        game_won, game_over out (all registered)
// Parameters: TICK_DIV sys_clk cycles per second (>= 2), READY_SEC countdown
// length in seconds (1..7).
// ---------------------------------------------------------------------------
module game_session_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int READY_SEC = 3
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    game_session_if.slave  bus
);

    game_state_e state_q;
    logic        timer_clr_q;
    logic        timer_tick_q;
    logic [2:0]  ready_cnt_q;
    logic        game_won_q;
    logic        game_over_q;
    logic        sec_pls;
    logic        restart;

    // start_pls restarts the session from every state except PLAY, where it
    // is ignored; the prescaler restarts its second on the same edge.
    assign restart = bus.start_pls && (state_q != ST_PLAY);

    sec_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_prescaler (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (is_counting(state_q)),
        .reload    (restart),
        .sec_pls   (sec_pls)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            timer_clr_q  <= 1'b0;
            timer_tick_q <= 1'b0;
            ready_cnt_q  <= 3'd0;
            game_won_q   <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            timer_clr_q  <= 1'b0;
            timer_tick_q <= 1'b0;
            if (restart) begin
                state_q     <= ST_READY;
                timer_clr_q <= 1'b1;
                ready_cnt_q <= 3'(READY_SEC);
                game_won_q  <= 1'b0;
                game_over_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_READY: begin
                        if (sec_pls) begin
                            if (ready_cnt_q == 3'd1) begin
                                state_q     <= ST_PLAY;
                                ready_cnt_q <= 3'd0;
                            end else begin
                                ready_cnt_q <= ready_cnt_q - 3'd1;
                            end
                        end
                    end
                    ST_PLAY: begin
                        // A completed second is counted even on the edge the
                        // game ends or pauses.
                        timer_tick_q <= sec_pls;
                        if (bus.win_evt) begin
                            state_q    <= ST_WON;
                            game_won_q <= 1'b1;
                        end else if (bus.lose_evt || bus.time_max_flag) begin
                            state_q     <= ST_OVER;
                            game_over_q <= 1'b1;
                        end else if (bus.pause_pls) begin
                            state_q <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        if (bus.pause_pls) begin
                            state_q <= ST_PLAY;
                        end
                    end
                    default: begin
                        // IDLE, WON and OVER only leave through restart.
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign bus.state      = state_q;
    assign bus.timer_clr  = timer_clr_q;
    assign bus.timer_tick = timer_tick_q;
    assign bus.ready_cnt  = ready_cnt_q;
    assign bus.game_won   = game_won_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_session_ctrl
// Directed session scenarios followed by random button/event traffic. Every
// cycle the DUT outputs are compared with a session model that tracks the
// game in terms of elapsed running cycles and elapsed countdown seconds.
// ---------------------------------------------------------------------------
module tb_game_session_ctrl;

    localparam int TD = 4;
    localparam int RS = 3;

    // -------------------------------------------------------------- clock/reset
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    game_session_if bus();

    game_session_ctrl #(
        .TICK_DIV  (TD),
        .READY_SEC (RS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tick_seen;

    // ------------------------------------------------------------------- model
    // Session numbers: 0 idle, 1 ready, 2 play, 3 pause, 4 won, 5 over.
    // m_run counts cycles spent running (ready/play) since the last (re)start;
    // a game second completes on the running cycle whose index+1 is a multiple
    // of TD. m_rsec counts countdown seconds already shown.
    int   m_state;
    int   m_run;
    int   m_rsec;
    logic m_clr;
    logic m_tick;

    task automatic model_reset();
        m_state = 0;
        m_run   = 0;
        m_rsec  = 0;
        m_clr   = 1'b0;
        m_tick  = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic pa, input logic w,
                              input logic l, input logic mx);
        bit running;
        bit second;
        running = (m_state == 1) || (m_state == 2);
        second  = running && ((m_run + 1) % TD == 0);
        m_clr   = 1'b0;
        m_tick  = 1'b0;
        if (st && m_state != 2) begin
            m_state = 1;
            m_clr   = 1'b1;
            m_rsec  = 0;
            m_run   = 0;
        end else begin
            if (running) m_run++;
            if (m_state == 1) begin
                if (second) begin
                    m_rsec++;
                    if (m_rsec == RS) m_state = 2;
                end
            end else if (m_state == 2) begin
                m_tick = second;
                if (w)            m_state = 4;
                else if (l || mx) m_state = 5;
                else if (pa)      m_state = 3;
            end else if (m_state == 3) begin
                if (pa) m_state = 2;
            end
        end
    endtask

    // -------------------------------------------------------------- scoreboard
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state",      8'(bus.state),      8'(m_state));
        chk("ready_cnt",  8'(bus.ready_cnt),  (m_state == 1) ? 8'(RS - m_rsec) : 8'd0);
        chk("timer_clr",  8'(bus.timer_clr),  8'(m_clr));
        chk("timer_tick", 8'(bus.timer_tick), 8'(m_tick));
        chk("game_won",   8'(bus.game_won),   (m_state == 4) ? 8'd1 : 8'd0);
        chk("game_over",  8'(bus.game_over),  (m_state == 5) ? 8'd1 : 8'd0);
    endtask

    // ------------------------------------------------------------------ driver
    task automatic step(input logic st, input logic pa, input logic w,
                        input logic l, input logic mx);
        bus.start_pls     = st;
        bus.pause_pls     = pa;
        bus.win_evt       = w;
        bus.lose_evt      = l;
        bus.time_max_flag = mx;
        @(posedge sys_clk);
        model_edge(st, pa, w, l, mx);
        #1;
        bus.start_pls     = 1'b0;
        bus.pause_pls     = 1'b0;
        bus.win_evt       = 1'b0;
        bus.lose_evt      = 1'b0;
        bus.time_max_flag = 1'b0;
        if (bus.timer_tick === 1'b1) tick_seen++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        bus.start_pls     = 1'b0;
        bus.pause_pls     = 1'b0;
        bus.win_evt       = 1'b0;
        bus.lose_evt      = 1'b0;
        bus.time_max_flag = 1'b0;
        tick_seen         = 0;
        model_reset();

        // reset state
        #12;
        check_all();
        sys_rst_n = 1'b1;

        // 1: start, countdown 3,2,1, play after 12 cycles, first tick 4 later
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_clr", 8'(bus.timer_clr), 8'd1);
        chk("t1_ready3", 8'(bus.ready_cnt), 8'd3);
        idle(11);
        chk("t1_ready1", 8'(bus.ready_cnt), 8'd1);
        idle(1);
        chk("t1_play", 8'(bus.state), 8'd2);
        idle(3);
        chk("t1_no_early_tick", 8'(bus.timer_tick), 8'd0);
        idle(1);
        chk("t1_first_tick", 8'(bus.timer_tick), 8'd1);

        // 2: pause 2 cycles after a tick, no ticks while paused, resume
        idle(1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_pause", 8'(bus.state), 8'd3);
        tick_seen = 0;
        idle(20);
        chk("t2_no_tick_in_pause", 8'(tick_seen), 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("t2_resume_gap", 8'(bus.timer_tick), 8'd0);
        idle(1);
        chk("t2_resume_tick", 8'(bus.timer_tick), 8'd1);

        // 3: win and lose together -> won; later lose ignored
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t3_won", 8'(bus.game_won), 8'd1);
        chk("t3_not_over", 8'(bus.game_over), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_stays_won", 8'(bus.state), 8'd4);

        // 4: timer saturation -> over, no ticks, then restart
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(12);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_over", 8'(bus.state), 8'd5);
        tick_seen = 0;
        idle(10);
        chk("t4_no_tick_over", 8'(tick_seen), 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_restart_clr", 8'(bus.timer_clr), 8'd1);
        chk("t4_restart_ready", 8'(bus.ready_cnt), 8'd3);
        chk("t4_over_cleared", 8'(bus.game_over), 8'd0);

        // 6: start ignored in play; start at ready_cnt=1 reloads
        idle(12);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_play_ignores_start", 8'(bus.state), 8'd2);
        chk("t6_no_clr_in_play", 8'(bus.timer_clr), 8'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);
        chk("t6_ready1", 8'(bus.ready_cnt), 8'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_reload3", 8'(bus.ready_cnt), 8'd3);
        chk("t6_reload_clr", 8'(bus.timer_clr), 8'd1);

        // 5: asynchronous reset mid-pause
        idle(12);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        @(negedge sys_clk);
        #1 sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t5_idle", 8'(bus.state), 8'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 29) == 0,
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 79) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
